// File: rtl/idecode_pipe.sv
// MIPS32 instruction decode stage: register file with optional write bypass,
// immediate/destination decode, load-use interlock and an elastic ID/EX register.
module idecode_pipe #(
    parameter int DATA_W    = 32,
    parameter int NREG      = 32,
    parameter bit BYPASS_EN = 1'b1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc4,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata1,
    output logic [DATA_W-1:0] out_rdata2,
    output logic [DATA_W-1:0] out_imm,
    output logic [AW-1:0]     out_dst,
    output logic [4:0]        out_shamt,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc4
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LW      = 6'h23;

    state_t state, state_nx;

    logic [DATA_W-1:0] regs [NREG];

    logic [5:0]        in_op;
    logic [AW-1:0]     in_rs, in_rt, in_rd, ex_rt;
    logic [DATA_W-1:0] rd1, rd2, imm_ext;
    logic [AW-1:0]     dst;
    logic              wb_fire, hazard, advance, xfer;

    assign in_op   = in_instr[31:26];
    assign in_rs   = AW'(in_instr[25:21]);
    assign in_rt   = AW'(in_instr[20:16]);
    assign in_rd   = AW'(in_instr[15:11]);
    assign ex_rt   = AW'(out_instr[20:16]);
    assign wb_fire = wb_en && (wb_addr != '0);

    // Register file; entry 0 is never written and always reads as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_fire) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rd1 = regs[in_rs];
        if (in_rs == '0)
            rd1 = '0;
        else if (BYPASS_EN && wb_fire && (wb_addr == in_rs))
            rd1 = wb_data;
    end

    always_comb begin
        rd2 = regs[in_rt];
        if (in_rt == '0)
            rd2 = '0;
        else if (BYPASS_EN && wb_fire && (wb_addr == in_rt))
            rd2 = wb_data;
    end

    always_comb begin
        if (in_op == OP_ANDI || in_op == OP_ORI || in_op == OP_XORI)
            imm_ext = {{(DATA_W-16){1'b0}}, in_instr[15:0]};
        else
            imm_ext = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
    end

    always_comb begin
        if (in_op == OP_SPECIAL)
            dst = in_rd;
        else if (in_op == OP_JAL)
            dst = AW'(NREG - 1);
        else
            dst = in_rt;
    end

    // Load-use: the loaded register is not available until after the lw leaves ID/EX.
    assign hazard  = out_valid && (out_instr[31:26] == OP_LW) && (ex_rt != '0) &&
                     in_valid && ((in_rs == ex_rt) || (in_rt == ex_rt));
    assign advance = !out_valid || out_ready;
    assign in_ready = flush || (advance && (state != STALL) && !hazard);
    assign xfer     = in_valid && in_ready && !flush;

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (hazard && advance) state_nx = STALL;
            STALL:   state_nx = RUN;
            default: state_nx = RUN;
        endcase
        if (flush) state_nx = RUN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            out_valid  <= 1'b0;
            out_rdata1 <= '0;
            out_rdata2 <= '0;
            out_imm    <= '0;
            out_dst    <= '0;
            out_shamt  <= '0;
            out_instr  <= '0;
            out_pc4    <= '0;
        end else begin
            state <= state_nx;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (xfer) begin
                out_valid  <= 1'b1;
                out_rdata1 <= rd1;
                out_rdata2 <= rd2;
                out_imm    <= imm_ext;
                out_dst    <= dst;
                out_shamt  <= in_instr[10:6];
                out_instr  <= in_instr;
                out_pc4    <= in_pc4;
            end else if (advance) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
